garage_occupancy_ctrl: RTL and testbench
========================================

# garage_occupancy_ctrl

Parametrised parking-garage controller. Tracks per-ID occupancy and entry timestamps for up to CAPACITY cars, grants or denies entries, and computes a saturated parking cost on each exit. It sits between the IR entry/exit detection logic and the display/billing logic. It replaces the fixed 3-car controller that had an external count and no ID validation.

## Interface
Parameters:
- CAPACITY, 3: maximum cars present; must satisfy 1 ≤ CAPACITY ≤ 2^ID_W−1
- ID_W, 2: car ID width; ID 0 is invalid
- TIME_W, 16: timestamp counter width
- COST_W, 16: cost output width
- RATE, 1: cost units per elapsed tick
- BASE_FEE, 0: cost units added per exit
- CNT_W, $clog2(CAPACITY+1): derived count width

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- tick  in  1  time-base enable; timer increments when high
- entry_detected  in  1  single-cycle entry request pulse
- entry_id  in  ID_W  ID sampled with entry_detected
- exit_detected  in  1  single-cycle exit request pulse
- exit_id  in  ID_W  ID sampled with exit_detected
- car_count  out  CNT_W  cars present
- full  out  1  car_count == CAPACITY
- empty  out  1  car_count == 0
- entry_grant  out  1  one-cycle pulse, entry accepted
- entry_deny  out  1  one-cycle pulse, entry rejected
- entry_overrun  out  1  one-cycle pulse, entry request dropped
- exit_error  out  1  one-cycle pulse, exit rejected
- exit_overrun  out  1  one-cycle pulse, exit request dropped
- cost_valid  out  1  one-cycle pulse, cost valid
- cost  out  COST_W  held until the next cost_valid
- busy  out  1  FSM not in IDLE
- state  out  2  current FSM state

## Operation
- Request capture: each pulse loads a one-deep pending slot (valid flag + ID). A pulse arriving while its slot is valid and not being dispatched that cycle is dropped, and the matching *_overrun pulses. A pulse arriving in the dispatch cycle loads the freed slot.
- States: IDLE=0, PROCESS_ENTRY=1, PROCESS_EXIT=2, CALCULATE_COST=3.
- IDLE: pending exit → PROCESS_EXIT (exit has priority); else pending entry → PROCESS_ENTRY; dispatch clears the slot.
- PROCESS_ENTRY transitions to IDLE. An entry is valid when all hold:
  - id ≠ 0
  - the id's present bit is clear
  - car_count < CAPACITY
- Valid entry: set the present bit, store timer in stamp[id], increment car_count, pulse entry_grant. Otherwise pulse entry_deny and change no state.
- PROCESS_EXIT: if id = 0 or the id is absent, pulse exit_error and go to IDLE. Otherwise latch elapsed = (timer − stamp[id]) mod 2^TIME_W and go to CALCULATE_COST.
- CALCULATE_COST: cost = BASE_FEE + elapsed×RATE, computed at full width, then saturated to 2^COST_W−1. Clear the present bit, decrement car_count, pulse cost_valid, go to IDLE.
- Timer: free-running TIME_W counter, wraps to 0. Elapsed time is correct for stays shorter than 2^TIME_W ticks.
- Reset: all state, pending slots, present bits and timer clear; state=IDLE; car_count=0; empty=1; all other outputs 0. Reset mid-operation aborts the operation with no response pulse.

## Timing
- All outputs are registered.
- Entry pulse in cycle N:
  - slot valid in N+1
  - PROCESS_ENTRY in N+2
  - grant/deny and updated car_count/full/empty in N+3
- Exit pulse in cycle N:
  - PROCESS_EXIT in N+2
  - exit_error in N+3, or CALCULATE_COST in N+3
  - cost_valid, cost and updated car_count in N+4
- Simultaneous entry and exit pulses: exit is served first; the entry dispatches from the next IDLE cycle that has no pending exit.
- A tick in the cycle the stamp is written is not counted for that car.

## Test plan
- Reset, then entries for IDs 1, 2, 3 with CAPACITY=3 → three entry_grant pulses, each 3 cycles after its request; car_count 1→2→3; full=1 after the third.
- Full garage, entry for ID 1 → entry_deny; car_count stays 3. Entry for ID 0 on an empty garage → entry_deny.
- ID 2 enters at timer=100, exits at timer=130, RATE=2, BASE_FEE=5 → cost_valid 4 cycles after the exit request with cost=65; car_count decrements.
- Timer wrap: stamp=65530, exit at 4, TIME_W=16 → elapsed=10, cost=10 (RATE=1). With COST_W=4 and elapsed=20 → cost=15 (saturated).
- Exit for an absent ID 3 → exit_error, no cost_valid, count unchanged. Same-cycle entry(1) and exit(2), both valid → cost_valid precedes entry_grant.
- Second entry pulse while one is pending → entry_overrun. Reset asserted during CALCULATE_COST → no cost_valid; all outputs at reset values next cycle.

Source files
------------

// File: rtl/garage_occupancy_ctrl_if.sv
// Signal bundle between IR detection, the occupancy controller and display/billing.
// The master modport is the detection/billing side; the slave modport is the controller.
interface garage_occupancy_ctrl_if #(
  parameter int unsigned ID_W   = 2,
  parameter int unsigned COST_W = 16,
  parameter int unsigned CNT_W  = 2
);
  logic              tick;
  logic              entry_detected;
  logic [ID_W-1:0]   entry_id;
  logic              exit_detected;
  logic [ID_W-1:0]   exit_id;
  logic [CNT_W-1:0]  car_count;
  logic              full;
  logic              empty;
  logic              entry_grant;
  logic              entry_deny;
  logic              entry_overrun;
  logic              exit_error;
  logic              exit_overrun;
  logic              cost_valid;
  logic [COST_W-1:0] cost;
  logic              busy;
  logic [1:0]        state;

  modport master (
    output tick, entry_detected, entry_id, exit_detected, exit_id,
    input  car_count, full, empty, entry_grant, entry_deny, entry_overrun,
    input  exit_error, exit_overrun, cost_valid, cost, busy, state
  );

  modport slave (
    input  tick, entry_detected, entry_id, exit_detected, exit_id,
    output car_count, full, empty, entry_grant, entry_deny, entry_overrun,
    output exit_error, exit_overrun, cost_valid, cost, busy, state
  );
endinterface

// File: rtl/garage_occupancy_ctrl.sv
// Parking-garage occupancy controller: per-ID presence and entry stamps, entry
// admission, and saturated cost computation on exit. All outputs are registered.
module garage_occupancy_ctrl #(
  parameter int unsigned CAPACITY = 3,
  parameter int unsigned ID_W     = 2,
  parameter int unsigned TIME_W   = 16,
  parameter int unsigned COST_W   = 16,
  parameter int unsigned RATE     = 1,
  parameter int unsigned BASE_FEE = 0,
  parameter int unsigned CNT_W    = $clog2(CAPACITY + 1)
) (
  input logic                    clk,
  input logic                    reset,
  garage_occupancy_ctrl_if.slave bus
);
  localparam int unsigned NumIds = 2 ** ID_W;
  // Wide enough for elapsed*RATE+BASE_FEE with no overflow before saturation.
  localparam int unsigned FullW  = (TIME_W + 33 > COST_W + 1) ? TIME_W + 33 : COST_W + 1;
  localparam logic [CNT_W-1:0] CapCnt = CNT_W'(CAPACITY);

  typedef enum logic [1:0] {
    StIdle          = 2'd0,
    StProcessEntry  = 2'd1,
    StProcessExit   = 2'd2,
    StCalculateCost = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [TIME_W-1:0] timer_q, timer_d;
  logic              ent_pend_q, ent_pend_d;
  logic [ID_W-1:0]   ent_id_q, ent_id_d;
  logic              ex_pend_q, ex_pend_d;
  logic [ID_W-1:0]   ex_id_q, ex_id_d;
  logic              ent_disp, ex_disp;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic [NumIds-1:0] present_q, present_d;
  logic [TIME_W-1:0] stamp_q [NumIds];
  logic              stamp_we;
  logic [TIME_W-1:0] elapsed_q, elapsed_d;
  logic [FullW-1:0]  cost_full;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, empty_q, busy_q;
  logic              grant_q, grant_d;
  logic              deny_q, deny_d;
  logic              ent_ovr_q, ent_ovr_d;
  logic              ex_err_q, ex_err_d;
  logic              ex_ovr_q, ex_ovr_d;
  logic              cost_valid_q, cost_valid_d;
  logic [COST_W-1:0] cost_q, cost_d;

  assign timer_d   = timer_q + TIME_W'(bus.tick);
  assign cost_full = FullW'(elapsed_q) * FullW'(RATE) + FullW'(BASE_FEE);

  // One-deep request slots; a slot freed by dispatch can be refilled in the same cycle.
  always_comb begin
    ent_pend_d = ent_pend_q;
    ent_id_d   = ent_id_q;
    ent_ovr_d  = 1'b0;
    ex_pend_d  = ex_pend_q;
    ex_id_d    = ex_id_q;
    ex_ovr_d   = 1'b0;
    if (ent_disp) ent_pend_d = 1'b0;
    if (ex_disp) ex_pend_d = 1'b0;
    if (bus.entry_detected) begin
      if (ent_pend_q && !ent_disp) begin
        ent_ovr_d = 1'b1;
      end else begin
        ent_pend_d = 1'b1;
        ent_id_d   = bus.entry_id;
      end
    end
    if (bus.exit_detected) begin
      if (ex_pend_q && !ex_disp) begin
        ex_ovr_d = 1'b1;
      end else begin
        ex_pend_d = 1'b1;
        ex_id_d   = bus.exit_id;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_id_d     = cur_id_q;
    present_d    = present_q;
    count_d      = count_q;
    elapsed_d    = elapsed_q;
    cost_d       = cost_q;
    stamp_we     = 1'b0;
    ent_disp     = 1'b0;
    ex_disp      = 1'b0;
    grant_d      = 1'b0;
    deny_d       = 1'b0;
    ex_err_d     = 1'b0;
    cost_valid_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (ex_pend_q) begin
          ex_disp  = 1'b1;
          cur_id_d = ex_id_q;
          state_d  = StProcessExit;
        end else if (ent_pend_q) begin
          ent_disp = 1'b1;
          cur_id_d = ent_id_q;
          state_d  = StProcessEntry;
        end
      end
      StProcessEntry: begin
        state_d = StIdle;
        if ((cur_id_q != '0) && !present_q[cur_id_q] && (count_q < CapCnt)) begin
          present_d[cur_id_q] = 1'b1;
          stamp_we            = 1'b1;
          count_d             = count_q + CNT_W'(1);
          grant_d             = 1'b1;
        end else begin
          deny_d = 1'b1;
        end
      end
      StProcessExit: begin
        if ((cur_id_q == '0) || !present_q[cur_id_q]) begin
          ex_err_d = 1'b1;
          state_d  = StIdle;
        end else begin
          elapsed_d = timer_q - stamp_q[cur_id_q];
          state_d   = StCalculateCost;
        end
      end
      StCalculateCost: begin
        if (|cost_full[FullW-1:COST_W]) cost_d = '1;
        else cost_d = cost_full[COST_W-1:0];
        present_d[cur_id_q] = 1'b0;
        count_d             = count_q - CNT_W'(1);
        cost_valid_d        = 1'b1;
        state_d             = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      ent_pend_q   <= 1'b0;
      ent_id_q     <= '0;
      ex_pend_q    <= 1'b0;
      ex_id_q      <= '0;
      cur_id_q     <= '0;
      present_q    <= '0;
      elapsed_q    <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      busy_q       <= 1'b0;
      grant_q      <= 1'b0;
      deny_q       <= 1'b0;
      ent_ovr_q    <= 1'b0;
      ex_err_q     <= 1'b0;
      ex_ovr_q     <= 1'b0;
      cost_valid_q <= 1'b0;
      cost_q       <= '0;
      for (int i = 0; i < NumIds; i++) stamp_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      ent_pend_q   <= ent_pend_d;
      ent_id_q     <= ent_id_d;
      ex_pend_q    <= ex_pend_d;
      ex_id_q      <= ex_id_d;
      cur_id_q     <= cur_id_d;
      present_q    <= present_d;
      elapsed_q    <= elapsed_d;
      count_q      <= count_d;
      full_q       <= (count_d == CapCnt);
      empty_q      <= (count_d == '0);
      busy_q       <= (state_d != StIdle);
      grant_q      <= grant_d;
      deny_q       <= deny_d;
      ent_ovr_q    <= ent_ovr_d;
      ex_err_q     <= ex_err_d;
      ex_ovr_q     <= ex_ovr_d;
      cost_valid_q <= cost_valid_d;
      cost_q       <= cost_d;
      // Post-tick timer value, so a tick in the stamping cycle is not billed.
      if (stamp_we) stamp_q[cur_id_q] <= timer_d;
    end
  end

  assign bus.car_count     = count_q;
  assign bus.full          = full_q;
  assign bus.empty         = empty_q;
  assign bus.entry_grant   = grant_q;
  assign bus.entry_deny    = deny_q;
  assign bus.entry_overrun = ent_ovr_q;
  assign bus.exit_error    = ex_err_q;
  assign bus.exit_overrun  = ex_ovr_q;
  assign bus.cost_valid    = cost_valid_q;
  assign bus.cost          = cost_q;
  assign bus.busy          = busy_q;
  assign bus.state         = state_q;
endmodule

// File: tb/tb_garage_occupancy_ctrl.sv
// Scoreboard bench: stimulus queues expected response pulses with their cycle;
// a negedge monitor pops and compares whenever either controller pulses an output.
module tb_garage_occupancy_ctrl;
  localparam int KGrant = 0;
  localparam int KDeny  = 1;
  localparam int KEovr  = 2;
  localparam int KXerr  = 3;
  localparam int KXovr  = 4;
  localparam int KCost  = 5;

  typedef struct {
    int kind;
    int cyc;
    int cost;
    int cnt;
  } ev_t;

  logic clk = 1'b0;
  logic reset_a;
  logic reset_b;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  qa[$];
  ev_t  qb[$];

  garage_occupancy_ctrl_if #(.ID_W(2), .COST_W(16), .CNT_W(2)) ifa ();
  garage_occupancy_ctrl_if #(.ID_W(2), .COST_W(4), .CNT_W(2)) ifb ();

  garage_occupancy_ctrl #(
    .CAPACITY(3), .ID_W(2), .TIME_W(16), .COST_W(16), .RATE(2), .BASE_FEE(5)
  ) dut_a (
    .clk  (clk),
    .reset(reset_a),
    .bus  (ifa)
  );

  garage_occupancy_ctrl #(
    .CAPACITY(3), .ID_W(2), .TIME_W(8), .COST_W(4), .RATE(1), .BASE_FEE(0)
  ) dut_b (
    .clk  (clk),
    .reset(reset_b),
    .bus  (ifb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_ev(input int dut, input int kind, input int cost_v, input int cnt_v,
                          input int full_v, input int empty_v);
    ev_t e;
    bit  have;
    checks++;
    have = 1'b0;
    if (dut == 0 && qa.size() > 0) begin
      e    = qa.pop_front();
      have = 1'b1;
    end else if (dut == 1 && qb.size() > 0) begin
      e    = qb.pop_front();
      have = 1'b1;
    end
    if (!have) begin
      errors++;
      $display("FAIL dut%0d_unexpected: got pulse kind %0d at cycle %0d, required none",
               dut, kind, cyc);
      return;
    end
    if (e.kind != kind || e.cyc != cyc) begin
      errors++;
      $display("FAIL dut%0d_event: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
               dut, kind, cyc, e.kind, e.cyc);
    end
    if (e.kind == KCost) begin
      checks++;
      if (cost_v != e.cost) begin
        errors++;
        $display("FAIL dut%0d_cost: got %0d, required %0d", dut, cost_v, e.cost);
      end
    end
    if (e.cnt >= 0) begin
      checks++;
      if (cnt_v != e.cnt || full_v != int'(e.cnt == 3) || empty_v != int'(e.cnt == 0)) begin
        errors++;
        $display("FAIL dut%0d_count: got cnt=%0d full=%0d empty=%0d, required cnt=%0d", dut,
                 cnt_v, full_v, empty_v, e.cnt);
      end
    end
  endtask

  task automatic mon(input int dut, input logic g, input logic d, input logic eo,
                     input logic xe, input logic xo, input logic cv, input int cost_v,
                     input int cnt_v, input int full_v, input int empty_v);
    if (g) check_ev(dut, KGrant, cost_v, cnt_v, full_v, empty_v);
    if (d) check_ev(dut, KDeny, cost_v, cnt_v, full_v, empty_v);
    if (eo) check_ev(dut, KEovr, cost_v, cnt_v, full_v, empty_v);
    if (xe) check_ev(dut, KXerr, cost_v, cnt_v, full_v, empty_v);
    if (xo) check_ev(dut, KXovr, cost_v, cnt_v, full_v, empty_v);
    if (cv) check_ev(dut, KCost, cost_v, cnt_v, full_v, empty_v);
  endtask

  always @(negedge clk) begin
    mon(0, ifa.entry_grant, ifa.entry_deny, ifa.entry_overrun, ifa.exit_error,
        ifa.exit_overrun, ifa.cost_valid, int'(ifa.cost), int'(ifa.car_count),
        int'(ifa.full), int'(ifa.empty));
    mon(1, ifb.entry_grant, ifb.entry_deny, ifb.entry_overrun, ifb.exit_error,
        ifb.exit_overrun, ifb.cost_valid, int'(ifb.cost), int'(ifb.car_count),
        int'(ifb.full), int'(ifb.empty));
  end

  task automatic push(input int dut, input int kind, input int dly, input int cost_v,
                      input int cnt_v);
    ev_t e;
    e.kind = kind;
    e.cyc  = cyc + dly;
    e.cost = cost_v;
    e.cnt  = cnt_v;
    if (dut == 0) qa.push_back(e);
    else qb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic req(input int dut, input bit ent, input int eid, input bit ex, input int xid);
    if (dut == 0) begin
      ifa.entry_detected = ent;
      ifa.entry_id       = 2'(eid);
      ifa.exit_detected  = ex;
      ifa.exit_id        = 2'(xid);
    end else begin
      ifb.entry_detected = ent;
      ifb.entry_id       = 2'(eid);
      ifb.exit_detected  = ex;
      ifb.exit_id        = 2'(xid);
    end
    idle(1);
    ifa.entry_detected = 1'b0;
    ifa.exit_detected  = 1'b0;
    ifb.entry_detected = 1'b0;
    ifb.exit_detected  = 1'b0;
  endtask

  task automatic advance(input int dut, input int n);
    if (dut == 0) ifa.tick = 1'b1;
    else ifb.tick = 1'b1;
    idle(n);
    ifa.tick = 1'b0;
    ifb.tick = 1'b0;
  endtask

  initial begin
    ifa.tick = 1'b0; ifa.entry_detected = 1'b0; ifa.entry_id = '0;
    ifa.exit_detected = 1'b0; ifa.exit_id = '0;
    ifb.tick = 1'b0; ifb.entry_detected = 1'b0; ifb.entry_id = '0;
    ifb.exit_detected = 1'b0; ifb.exit_id = '0;
    reset_a = 1'b1;
    reset_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_a = 1'b0;
    reset_b = 1'b0;

    chk("rst_count", int'(ifa.car_count), 0);
    chk("rst_empty", int'(ifa.empty), 1);
    chk("rst_full", int'(ifa.full), 0);
    chk("rst_busy", int'(ifa.busy), 0);
    chk("rst_state", int'(ifa.state), 0);
    chk("rst_cost", int'(ifa.cost), 0);
    chk("rst_b_empty", int'(ifb.empty), 1);

    // ID 0 on empty garage is refused
    push(0, KDeny, 3, 0, 0); req(0, 1, 0, 0, 0); idle(5);

    // timer to 100, fill the garage with IDs 1..3
    advance(0, 100);
    push(0, KGrant, 3, 0, 1); req(0, 1, 1, 0, 0); idle(4);
    push(0, KGrant, 3, 0, 2); req(0, 1, 2, 0, 0); idle(4);
    push(0, KGrant, 3, 0, 3); req(0, 1, 3, 0, 0); idle(4);
    push(0, KDeny, 3, 0, 3);  req(0, 1, 1, 0, 0); idle(4);

    // ID 2 leaves at timer 130: 5 + 30*2 = 65
    advance(0, 30);
    push(0, KCost, 4, 65, 2); req(0, 0, 0, 1, 2); idle(6);
    push(0, KXerr, 3, 0, 2);  req(0, 0, 0, 1, 2); idle(5);

    // same-cycle exit(1) and entry(2): cost first, grant two cycles later
    push(0, KCost, 4, 65, 1); push(0, KGrant, 6, 0, 2); req(0, 1, 2, 1, 1); idle(8);

    // three back-to-back entry pulses: third one overruns the pending slot
    push(0, KGrant, 3, 0, 3); push(0, KEovr, 3, 0, -1); push(0, KDeny, 5, 0, 3);
    ifa.entry_detected = 1'b1; ifa.entry_id = 2'd1; idle(1);
    ifa.entry_id = 2'd1; idle(1);
    ifa.entry_id = 2'd0; idle(1);
    ifa.entry_detected = 1'b0; idle(6);

    // reset in CALCULATE_COST aborts the exit silently
    req(0, 0, 0, 1, 3); idle(2);
    chk("calc_state", int'(ifa.state), 3);
    chk("calc_busy", int'(ifa.busy), 1);
    reset_a = 1'b1; idle(1);
    chk("abort_cost_valid", int'(ifa.cost_valid), 0);
    chk("abort_count", int'(ifa.car_count), 0);
    chk("abort_empty", int'(ifa.empty), 1);
    chk("abort_full", int'(ifa.full), 0);
    chk("abort_state", int'(ifa.state), 0);
    chk("abort_cost", int'(ifa.cost), 0);
    reset_a = 1'b0;
    push(0, KGrant, 3, 0, 1); req(0, 1, 1, 0, 0); idle(5);

    // 8-bit timer wrap: stamp 250, exit at 4 -> elapsed 10
    advance(1, 250);
    push(1, KGrant, 3, 0, 1); req(1, 1, 1, 0, 0); idle(5);
    advance(1, 10);
    push(1, KCost, 4, 10, 0); req(1, 0, 0, 1, 1); idle(6);
    // elapsed 20 saturates a 4-bit cost at 15
    push(1, KGrant, 3, 0, 1); req(1, 1, 2, 0, 0); idle(5);
    advance(1, 20);
    push(1, KCost, 4, 15, 0); req(1, 0, 0, 1, 2); idle(6);

    idle(4);
    chk("sb_a_pending", qa.size(), 0);
    chk("sb_b_pending", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
